// File: rtl/tpu_job_ctrl.sv
// Job sequencer for the systolic TPU core: loads A/B operand lines, feeds the core,
// collects its result lines and drains them through a back-pressurable output stream.
module tpu_job_ctrl #(
  parameter int IN_W  = 256,
  parameter int OUT_W = 512,
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_clr,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_a,
  input  logic [IN_W-1:0]  in_b,
  output logic             tpu_in_valid,
  input  logic             tpu_in_ready,
  output logic [IN_W-1:0]  tpu_a,
  output logic [IN_W-1:0]  tpu_b,
  input  logic             tpu_out_valid,
  output logic             tpu_out_ready,
  input  logic [OUT_W-1:0] tpu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FEED, S_COLLECT, S_OUT, S_DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] len, len_m1, eff_len;
  logic [CNT_W-1:0] wr_cnt, rd_cnt, res_cnt;
  logic             in_hs, feed_hs, res_hs, out_hs;

  logic [IN_W-1:0]  abuf [DEPTH];
  logic [IN_W-1:0]  bbuf [DEPTH];
  logic [OUT_W-1:0] obuf [DEPTH];

  // Zero or oversize lengths run a full-depth job.
  assign eff_len = (cfg_len == '0 || cfg_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cfg_len;
  assign len_m1  = len - CNT_W'(1);

  assign in_hs   = in_valid && in_ready && !soft_clr;
  assign feed_hs = tpu_in_valid && tpu_in_ready && !soft_clr;
  assign res_hs  = tpu_out_valid && tpu_out_ready && !soft_clr;
  assign out_hs  = out_valid && out_ready && !soft_clr;

  assign busy     = (state != S_IDLE);
  assign tpu_a    = tpu_in_valid ? abuf[rd_cnt[AW-1:0]] : '0;
  assign tpu_b    = tpu_in_valid ? bbuf[rd_cnt[AW-1:0]] : '0;
  assign out_data = out_valid ? obuf[rd_cnt[AW-1:0]] : '0;

  always_comb begin
    state_n       = state;
    in_ready      = 1'b0;
    tpu_in_valid  = 1'b0;
    tpu_out_ready = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (eff_len == CNT_W'(1)) ? S_FEED : S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && wr_cnt == len_m1) state_n = S_FEED;
      end
      S_FEED: begin
        tpu_in_valid  = 1'b1;
        tpu_out_ready = (res_cnt < len);
        if (tpu_in_ready && rd_cnt == len_m1) state_n = S_COLLECT;
      end
      S_COLLECT: begin
        tpu_out_ready = (res_cnt < len);
        if (res_cnt == len || (tpu_out_valid && tpu_out_ready && res_cnt == len_m1))
          state_n = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_last  = (rd_cnt == len_m1);
        if (out_ready && out_last) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (soft_clr) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      len     <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      res_cnt <= '0;
    end else begin
      state <= state_n;
      if (soft_clr) begin
        wr_cnt  <= '0;
        rd_cnt  <= '0;
        res_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: if (in_hs) begin
            len     <= eff_len;
            wr_cnt  <= (eff_len == CNT_W'(1)) ? '0 : CNT_W'(1);
            rd_cnt  <= '0;
            res_cnt <= '0;
          end
          S_LOAD: if (in_hs) wr_cnt <= (wr_cnt == len_m1) ? '0 : wr_cnt + CNT_W'(1);
          S_FEED: begin
            // rd_cnt wraps to 0 after the last feed so OUT starts from line 0.
            if (feed_hs) rd_cnt <= (rd_cnt == len_m1) ? '0 : rd_cnt + CNT_W'(1);
            if (res_hs)  res_cnt <= res_cnt + CNT_W'(1);
          end
          S_COLLECT: if (res_hs) res_cnt <= res_cnt + CNT_W'(1);
          S_OUT:  if (out_hs) rd_cnt <= (rd_cnt == len_m1) ? '0 : rd_cnt + CNT_W'(1);
          S_DONE: res_cnt <= '0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs) begin
      abuf[wr_cnt[AW-1:0]] <= in_a;
      bbuf[wr_cnt[AW-1:0]] <= in_b;
    end
    if (res_hs) obuf[res_cnt[AW-1:0]] <= tpu_out;
  end

endmodule

// File: tb/tb_tpu_job_ctrl.sv
// Directed bench for tpu_job_ctrl with an A+B echo core model (3-cycle latency).
module tb_tpu_job_ctrl;
  localparam int IN_W  = 256;
  localparam int OUT_W = 512;
  localparam int DEPTH = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n, soft_clr;
  logic [CNT_W-1:0] cfg_len;
  logic             in_valid, in_ready;
  logic [IN_W-1:0]  in_a, in_b;
  logic             tpu_in_valid, tpu_in_ready;
  logic [IN_W-1:0]  tpu_a, tpu_b;
  logic             tpu_out_valid, tpu_out_ready;
  logic [OUT_W-1:0] tpu_out;
  logic             out_valid, out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last, busy, done;

  int errors = 0;
  int checks = 0;
  int feed_cnt = 0;
  int res_cnt_tb = 0;
  int done_cnt = 0;
  int unsigned cyc = 0;
  bit thr_core = 1'b0;

  tpu_job_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .tpu_in_valid(tpu_in_valid), .tpu_in_ready(tpu_in_ready), .tpu_a(tpu_a), .tpu_b(tpu_b),
    .tpu_out_valid(tpu_out_valid), .tpu_out_ready(tpu_out_ready), .tpu_out(tpu_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned      due;
    logic [OUT_W-1:0] val;
  } res_t;
  res_t cq[$];

  // Core model: sample handshakes at the edge, drive its outputs 1 time unit later.
  always @(posedge clk) begin
    res_t r;
    cyc++;
    if (!rst_n || soft_clr) cq.delete();
    else begin
      if (tpu_out_valid && tpu_out_ready) begin
        cq.delete(0);
        res_cnt_tb++;
      end
      if (tpu_in_valid && tpu_in_ready) begin
        r.due = cyc + 3;
        r.val = OUT_W'(tpu_a) + OUT_W'(tpu_b);
        cq.push_back(r);
        feed_cnt++;
      end
    end
    #1;
    tpu_out_valid = (cq.size() > 0) && (cq[0].due <= cyc);
    tpu_out       = tpu_out_valid ? cq[0].val : '0;
    tpu_in_ready  = thr_core ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_job(input int n, input int cfg, input int mid, input int abase,
                          input int bbase, input bit thr,
                          output int first_it, output logic done_first, output logic busy2);
    int i = 0;
    int it = 0;
    first_it = 0; done_first = 1'bx; busy2 = 1'bx;
    while (i < n && it < 4000) begin
      @(negedge clk);
      it++;
      if (it == 1) done_first = done;
      if (it == 2) busy2 = busy;
      cfg_len  = CNT_W'((i == 0) ? cfg : mid);
      in_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      in_a     = IN_W'(abase + i);
      in_b     = IN_W'(bbase + i);
      if (in_valid && in_ready) begin
        if (i == 0) first_it = it;
        i++;
      end
    end
    if (i < n) chk("send_timeout", i, n);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv_job(input int n, input int len, input int abase, input int bbase,
                          input bit thr);
    int k = 0;
    int g = 0;
    logic stall = 1'b0;
    logic [OUT_W-1:0] prev = '0;
    while (k < n && g < 5000) begin
      @(negedge clk);
      g++;
      if (stall) chk("hold_data", out_data, prev);
      if (out_valid) begin
        chk("out_data", out_data, OUT_W'(abase + bbase + 2 * k));
        chk("out_last", out_last, (k == len - 1));
      end
      out_ready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = out_valid && !out_ready;
      prev  = out_data;
      if (out_valid && out_ready) k++;
    end
    if (k < n) chk("recv_timeout", k, n);
  endtask

  typedef struct {
    int cfg; int mid; int exp_len; int abase; int bbase; bit thr;
  } job_t;
  localparam int NJ = 7;
  job_t jobs[NJ];

  initial begin
    int fi, g;
    logic df, b2;
    jobs[0] = '{cfg: 4,  mid: 4,  exp_len: 4,  abase: 0,   bbase: 16,  thr: 1'b0};
    jobs[1] = '{cfg: 0,  mid: 0,  exp_len: 32, abase: 0,   bbase: 16,  thr: 1'b0};
    jobs[2] = '{cfg: 7,  mid: 7,  exp_len: 7,  abase: 5,   bbase: 40,  thr: 1'b1};
    jobs[3] = '{cfg: 3,  mid: 9,  exp_len: 3,  abase: 100, bbase: 200, thr: 1'b0};
    jobs[4] = '{cfg: 5,  mid: 1,  exp_len: 5,  abase: 7,   bbase: 9,   thr: 1'b0};
    jobs[5] = '{cfg: 40, mid: 40, exp_len: 32, abase: 1,   bbase: 2,   thr: 1'b0};
    jobs[6] = '{cfg: 1,  mid: 3,  exp_len: 1,  abase: 3,   bbase: 4,   thr: 1'b0};

    rst_n = 1'b0; soft_clr = 1'b0; cfg_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    tpu_in_ready = 1'b1; tpu_out_valid = 1'b0; tpu_out = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_tpu_in_valid", tpu_in_valid, 0);
    chk("rst_tpu_out_ready", tpu_out_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_tpu_a", tpu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int j = 0; j < NJ; j++) begin
      feed_cnt = 0;
      thr_core = jobs[j].thr;
      send_job(jobs[j].exp_len, jobs[j].cfg, jobs[j].mid, jobs[j].abase, jobs[j].bbase,
               jobs[j].thr, fi, df, b2);
      if (!jobs[j].thr) begin
        if (j == 0) chk("first_beat_idle", fi, 1);
        else begin
          chk("first_beat_after_done", fi, 2);
          chk("done_before_next", df, 1);
          chk("busy_after_done", b2, 0);
        end
      end
      recv_job(jobs[j].exp_len, jobs[j].exp_len, jobs[j].abase, jobs[j].bbase, jobs[j].thr);
      chk("feed_count", feed_cnt, jobs[j].exp_len);
    end
    thr_core = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("last_done", done, 1);
    chk("done_in_ready", in_ready, 0);
    chk("done_tpu_a", tpu_a, 0);
    @(negedge clk);
    chk("done_count", done_cnt, NJ);
    chk("idle_busy", busy, 0);

    // Abort in COLLECT after two of four results.
    res_cnt_tb = 0;
    send_job(4, 4, 4, 20, 30, 1'b0, fi, df, b2);
    g = 0;
    while (!(res_cnt_tb == 2 && !tpu_in_valid) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("clr_reach_collect", res_cnt_tb, 2);
    chk("clr_pre_ready", tpu_out_ready, 1);
    soft_clr = 1'b1;
    @(negedge clk);
    soft_clr = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_tpu_out_ready", tpu_out_ready, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    send_job(2, 2, 2, 50, 60, 1'b0, fi, df, b2);
    recv_job(2, 2, 50, 60, 1'b0);
    @(negedge clk);
    chk("clr_job_done", done, 1);

    // Asynchronous reset in the middle of the output drain.
    send_job(4, 4, 4, 8, 11, 1'b0, fi, df, b2);
    recv_job(2, 4, 8, 11, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_in_ready", in_ready, 1);
    send_job(2, 2, 2, 70, 80, 1'b0, fi, df, b2);
    chk("post_rst_first_beat", fi, 1);
    recv_job(2, 2, 70, 80, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks expected completion", checks);
    $fatal(1);
  end
endmodule

// File: doc/tpu_job_ctrl.md
Name: tpu_job_ctrl

Overview:
Parametrised job sequencer for the systolic TPU core. Per job it:
- accepts a runtime-configurable number of A/B operand lines through a valid/ready stream into internal line buffers;
- streams those lines into the TPU core with a valid/ready handshake;
- collects the core's result lines into an output buffer;
- drains the results through a back-pressurable output stream with a last marker.

It sits between the testbench/DMA interface and the tpu core. It supports back-to-back jobs and synchronous abort.

Parameters:
IN_W, 256, operand line width (bits) of A and B lines
OUT_W, 512, result line width (bits)
DEPTH, 32, maximum lines per job (buffer depth), power of two, >=2
CNT_W, $clog2(DEPTH)+1, counter/length width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
soft_clr  in  1  synchronous abort; returns block to IDLE
cfg_len  in  CNT_W  lines in the job; sampled on the first accepted input beat
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted
in_a  in  IN_W  A operand line
in_b  in  IN_W  B operand line
tpu_in_valid  out  1  operand line valid to core
tpu_in_ready  in  1  core accepts operand line
tpu_a  out  IN_W  A line to core
tpu_b  out  IN_W  B line to core
tpu_out_valid  in  1  core result valid
tpu_out_ready  out  1  block accepts result
tpu_out  in  OUT_W  core result line
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
out_data  out  OUT_W  result line
out_last  out  1  final result beat of the job
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all counters 0; buffers need not be cleared.
  - tpu_in_valid, tpu_out_ready, out_valid, out_last, busy, done = 0; out_data, tpu_a, tpu_b = 0.
  - in_ready=1, since it is decoded from state IDLE.
- Effective length: len = (cfg_len==0 || cfg_len>DEPTH) ? DEPTH : cfg_len. It is latched on the IDLE handshake and held for the whole job; later cfg_len changes are ignored.
- States: IDLE, LOAD, FEED, COLLECT, OUT, DONE.
- IDLE:
  - in_ready=1.
  - Handshake (in_valid&&in_ready) writes line 0 and latches len; wr_cnt=1.
  - Next state is LOAD, or FEED if len==1.
- LOAD:
  - in_ready=1.
  - Each handshake writes line wr_cnt and increments wr_cnt.
  - When the handshake writes line len-1, go to FEED and clear counters.
  - in_valid=0 cycles stall with no effect.
- FEED:
  - in_ready=0; tpu_in_valid=1.
  - tpu_a/tpu_b = buffer[rd_cnt], combinational read; they are 0 whenever tpu_in_valid=0.
  - rd_cnt increments on tpu_in_ready.
  - After the handshake of line len-1, go to COLLECT.
  - tpu_out_ready=1 in FEED as well; results arriving early are captured.
- COLLECT:
  - tpu_out_ready=1 while res_cnt<len.
  - Each result handshake writes obuf[res_cnt] and increments res_cnt.
  - When res_cnt reaches len, tpu_out_ready drops the same cycle, and the block moves to OUT with rd_cnt=0.
  - Extra tpu_out_valid after len results is not accepted.
- OUT:
  - out_valid=1; out_data=obuf[rd_cnt]; out_last=(rd_cnt==len-1).
  - Data is held stable while out_ready=0.
  - rd_cnt increments on handshake.
  - After the last handshake, go to DONE.
- DONE:
  - Lasts one cycle with done=1, then IDLE.
  - in_ready=0 in DONE; the next job's first beat is accepted in IDLE, so the minimum gap between jobs is 1 cycle.
- Throughput: 1 line/cycle in LOAD, FEED and OUT when the partner is always ready.
  - Minimum job latency from the first input beat to the first out_valid is len + len + (core latency) + 1 cycles.
- soft_clr:
  - Highest priority in any state.
  - Next cycle: state=IDLE, counters 0, all valids/done 0.
  - A handshake coinciding with soft_clr is discarded.
  - Buffer contents are not cleared.
- Counters are CNT_W bits and never wrap within a job, because len<=DEPTH.

Test Plan:
- Reset, then cfg_len=4, 4 beats A=i, B=16+i, TPU model echoes A+B with 3-cycle latency, out_ready=1 -> out_data 16,18,20,22; out_last only on the 4th beat; single done pulse; busy low after DONE.
- cfg_len=0 -> 32 lines loaded; the FEED phase issues exactly 32 tpu_in_valid handshakes; 32 out beats.
- Random in_valid / tpu_in_ready / out_ready throttling (50%), len=7 -> no lost or duplicated lines; out_data held stable under out_ready=0; order preserved.
- Two back-to-back jobs, len=3 then len=5, second in_valid asserted in DONE -> first beat of job 2 accepted in the cycle after DONE; cfg_len change mid-job ignored.
- soft_clr asserted in COLLECT after 2 of 4 results -> IDLE next cycle; tpu_out_ready, out_valid=0; a new len=2 job completes correctly.
- rst_n pulsed low mid-OUT (asynchronous, between clock edges) -> out_valid, busy = 0 immediately; in_ready=1; state IDLE after release.
